// File: rtl/dma_priority_arbiter_if.sv
// ============================================================================
// Module  : dma_priority_arbiter_if
// Purpose : Request, acknowledge and command-register signals of the DMA arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface dma_priority_arbiter_if #(
  parameter int CHANNELS = 4
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0] DREQ;
  logic                HLDA;
  logic                EOP_N;
  logic                xferDone;
  logic [CHANNELS-1:0] maskBits;
  logic [CHANNELS-1:0] swReqSet;
  logic                ctrlDisable;
  logic                rotPri;
  logic                dreqSenseLow;
  logic                dackSenseHigh;
  logic                HRQ;
  logic [CHANNELS-1:0] DACK;
  logic                grantValid;
  logic [CW-1:0]       grantChan;
  logic [CHANNELS-1:0] reqStatus;

  modport slave (
    input  DREQ, HLDA, EOP_N, xferDone, maskBits, swReqSet,
           ctrlDisable, rotPri, dreqSenseLow, dackSenseHigh,
    output HRQ, DACK, grantValid, grantChan, reqStatus
  );

  modport master (
    output DREQ, HLDA, EOP_N, xferDone, maskBits, swReqSet,
           ctrlDisable, rotPri, dreqSenseLow, dackSenseHigh,
    input  HRQ, DACK, grantValid, grantChan, reqStatus
  );
endinterface

`default_nettype wire

// File: rtl/dma_priority_arbiter.sv
// ============================================================================
// Module  : dma_priority_arbiter
// Purpose : Hold-request / grant arbiter for DMA channels, fixed or rotating priority.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_priority_arbiter #(
  parameter int CHANNELS = 4
) (
  input wire logic             CLK,
  input wire logic             RESET,
  dma_priority_arbiter_if.slave bus
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_GRANT   = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                hrq_q, hrq_d;
  logic [CHANNELS-1:0] active_q, active_d;
  logic [CHANNELS-1:0] swreq_q, swreq_d;
  logic [CW-1:0]       chan_q, chan_d;
  logic [CW-1:0]       last_q, last_d;

  logic [CHANNELS-1:0] w_eff;
  logic [CHANNELS-1:0] w_sw_clr;
  logic [CW-1:0]       w_start;
  logic [CW-1:0]       w_win;
  logic                w_found;
  logic [CW:0]         w_idx;
  logic [CW-1:0]       w_idx_c;

  // Software requests bypass the mask register.
  assign w_eff = ((bus.DREQ ^ {CHANNELS{bus.dreqSenseLow}}) & ~bus.maskBits) | swreq_q;

  always_comb begin
    w_start = '0;
    if (bus.rotPri) begin
      w_start = (last_q == CW'(CHANNELS - 1)) ? '0 : last_q + 1'b1;
    end
    w_win   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    w_idx_c = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_idx = {1'b0, w_start} + (CW+1)'(k);
      if (w_idx >= (CW+1)'(CHANNELS)) begin
        w_idx = w_idx - (CW+1)'(CHANNELS);
      end
      w_idx_c = w_idx[CW-1:0];
      if (!w_found && w_eff[w_idx_c]) begin
        w_found = 1'b1;
        w_win   = w_idx_c;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    chan_d   = chan_q;
    last_d   = last_q;
    active_d = active_q;
    w_sw_clr = '0;
    case (state_q)
      S_IDLE: begin
        if (!bus.ctrlDisable && |w_eff) state_d = S_REQ;
      end
      S_REQ: begin
        if (bus.HLDA) begin
          if (w_found) begin
            state_d  = S_GRANT;
            chan_d   = w_win;
            active_d = CHANNELS'(1) << w_win;
          end else begin
            state_d = S_RELEASE;
          end
        end
      end
      S_GRANT: begin
        // A completed service outranks a simultaneous HLDA drop.
        if (bus.xferDone || !bus.EOP_N) begin
          state_d  = S_RELEASE;
          active_d = '0;
          w_sw_clr = active_q;
          last_d   = chan_q;
        end else if (!bus.HLDA) begin
          state_d  = S_RELEASE;
          active_d = '0;
        end
      end
      S_RELEASE: begin
        if (!bus.HLDA) state_d = S_IDLE;
      end
      default: begin
        state_d  = S_IDLE;
        active_d = '0;
      end
    endcase
    hrq_d   = (state_d == S_REQ) || (state_d == S_GRANT);
    swreq_d = (swreq_q & ~w_sw_clr) | bus.swReqSet;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= S_IDLE;
      hrq_q    <= 1'b0;
      active_q <= '0;
      swreq_q  <= '0;
      chan_q   <= '0;
      last_q   <= CW'(CHANNELS - 1);
    end else begin
      state_q  <= state_d;
      hrq_q    <= hrq_d;
      active_q <= active_d;
      swreq_q  <= swreq_d;
      chan_q   <= chan_d;
      last_q   <= last_d;
    end
  end

  assign bus.HRQ        = hrq_q;
  assign bus.DACK       = active_q ^ {CHANNELS{~bus.dackSenseHigh}};
  assign bus.grantValid = (state_q == S_GRANT);
  assign bus.grantChan  = chan_q;
  assign bus.reqStatus  = swreq_q;

endmodule

`default_nettype wire

// File: tb/tb_dma_priority_arbiter.sv
// ============================================================================
// Module  : tb_dma_priority_arbiter
// Purpose : Directed and randomized checks of dma_priority_arbiter against a transaction-level model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dma_priority_arbiter;
  localparam int N = 4;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  dma_priority_arbiter_if #(.CHANNELS(N)) bus();

  dma_priority_arbiter #(.CHANNELS(N)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  bit [N-1:0] sw_model;
  int         last_model;

  // Highest-priority channel among eff, or -1 when nothing requests.
  function automatic int exp_winner(input bit [N-1:0] eff, input bit rot, input int last);
    int start;
    start = rot ? (last + 1) % N : 0;
    for (int k = 0; k < N; k++) begin
      if (eff[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  function automatic bit [N-1:0] model_eff();
    return ((bus.DREQ ^ {N{bus.dreqSenseLow}}) & ~bus.maskBits) | sw_model;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_defaults();
    bus.DREQ = '0; bus.HLDA = 1'b0; bus.EOP_N = 1'b1; bus.xferDone = 1'b0;
    bus.maskBits = '0; bus.swReqSet = '0; bus.ctrlDisable = 1'b0;
    bus.rotPri = 1'b0; bus.dreqSenseLow = 1'b0; bus.dackSenseHigh = 1'b1;
  endtask

  task automatic hard_reset();
    RESET = 1'b0;
    #2;
    RESET = 1'b1;
    sw_model   = '0;
    last_model = N - 1;
  endtask

  task automatic wait_hrq(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      if (bus.HRQ === 1'b1) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    set_defaults();
    RESET = 1'b0;
    #12;
    checks++; if (bus.HRQ !== 1'b0) begin failures++; $display("FAIL reset_hrq got=%b exp=0", bus.HRQ); end
    checks++; if (bus.grantValid !== 1'b0) begin failures++; $display("FAIL reset_gv got=%b exp=0", bus.grantValid); end
    checks++; if (bus.grantChan !== 2'd0) begin failures++; $display("FAIL reset_chan got=%0d exp=0", bus.grantChan); end
    checks++; if (bus.reqStatus !== 4'b0000) begin failures++; $display("FAIL reset_status got=%b exp=0000", bus.reqStatus); end
    checks++; if (bus.DACK !== 4'b0000) begin failures++; $display("FAIL reset_dack got=%b exp=0000", bus.DACK); end
    bus.DREQ = 4'b0001;
    @(negedge CLK);
    RESET = 1'b1;
    sw_model = '0; last_model = N - 1;
    tick();
    checks++; if (bus.HRQ !== 1'b1) begin failures++; $display("FAIL first_req_hrq got=%b exp=1", bus.HRQ); end
    bus.DREQ = '0;
    bus.HLDA = 1'b1;
    tick();
    checks++; if (bus.HRQ !== 1'b0) begin failures++; $display("FAIL noreq_release_hrq got=%b exp=0", bus.HRQ); end
    checks++; if (bus.grantValid !== 1'b0) begin failures++; $display("FAIL noreq_release_gv got=%b exp=0", bus.grantValid); end
    tick();
    checks++; if (bus.HRQ !== 1'b0) begin failures++; $display("FAIL release_hold_hrq got=%b exp=0", bus.HRQ); end
    bus.HLDA = 1'b0;
    tick();
    tick();
    checks++; if (bus.HRQ !== 1'b0) begin failures++; $display("FAIL back_idle_hrq got=%b exp=0", bus.HRQ); end
  endtask

  task automatic test_fixed_priority();
    set_defaults();
    hard_reset();
    bus.DREQ = 4'b1010;
    tick();
    checks++; if (bus.HRQ !== 1'b1) begin failures++; $display("FAIL fixed_hrq_latency got=%b exp=1", bus.HRQ); end
    tick(); tick();
    bus.HLDA = 1'b1;
    tick();
    checks++; if (bus.grantValid !== 1'b1) begin failures++; $display("FAIL fixed_gv got=%b exp=1", bus.grantValid); end
    checks++; if (bus.grantChan !== 2'd1) begin failures++; $display("FAIL fixed_chan got=%0d exp=1", bus.grantChan); end
    checks++; if (bus.DACK !== 4'b0010) begin failures++; $display("FAIL fixed_dack got=%b exp=0010", bus.DACK); end
    bus.DREQ = 4'b1011;
    tick(); tick();
    checks++; if (bus.grantChan !== 2'd1) begin failures++; $display("FAIL fixed_hold_chan got=%0d exp=1", bus.grantChan); end
    checks++; if (bus.DACK !== 4'b0010) begin failures++; $display("FAIL fixed_hold_dack got=%b exp=0010", bus.DACK); end
    bus.xferDone = 1'b1;
    tick();
    bus.xferDone = 1'b0;
    checks++; if (bus.HRQ !== 1'b0) begin failures++; $display("FAIL fixed_done_hrq got=%b exp=0", bus.HRQ); end
    checks++; if (bus.DACK !== 4'b0000) begin failures++; $display("FAIL fixed_done_dack got=%b exp=0000", bus.DACK); end
    bus.DREQ = '0;
    bus.HLDA = 1'b0;
    tick();
  endtask

  task automatic test_rotating();
    bit ok;
    int exp;
    set_defaults();
    hard_reset();
    bus.rotPri = 1'b1;
    bus.DREQ = 4'b1111;
    for (int s = 0; s < 3; s++) begin
      wait_hrq(ok);
      checks++; if (!ok) begin failures++; $display("FAIL rot_hrq_timeout service=%0d", s); end
      bus.HLDA = 1'b1;
      tick();
      exp = exp_winner(model_eff(), 1'b1, last_model);
      checks++; if (bus.grantChan !== 2'(exp)) begin failures++; $display("FAIL rot_chan service=%0d got=%0d exp=%0d", s, bus.grantChan, exp); end
      bus.xferDone = 1'b1;
      tick();
      bus.xferDone = 1'b0;
      last_model = exp;
      bus.HLDA = 1'b0;
      tick();
    end
    bus.DREQ = '0;
  endtask

  task automatic test_mask_sw();
    bit ok;
    set_defaults();
    hard_reset();
    bus.maskBits = 4'b0001;
    bus.DREQ = 4'b0001;
    tick(); tick(); tick();
    checks++; if (bus.HRQ !== 1'b0) begin failures++; $display("FAIL mask_hrq got=%b exp=0", bus.HRQ); end
    bus.swReqSet = 4'b0001;
    tick();
    bus.swReqSet = '0;
    sw_model[0] = 1'b1;
    checks++; if (bus.reqStatus !== sw_model) begin failures++; $display("FAIL sw_status got=%b exp=%b", bus.reqStatus, sw_model); end
    wait_hrq(ok);
    checks++; if (!ok) begin failures++; $display("FAIL sw_hrq_timeout"); end
    bus.HLDA = 1'b1;
    tick();
    checks++; if (bus.DACK !== 4'b0001) begin failures++; $display("FAIL sw_dack got=%b exp=0001", bus.DACK); end
    bus.xferDone = 1'b1;
    tick();
    bus.xferDone = 1'b0;
    sw_model[0] = 1'b0;
    checks++; if (bus.reqStatus !== sw_model) begin failures++; $display("FAIL sw_clear got=%b exp=%b", bus.reqStatus, sw_model); end
    bus.HLDA = 1'b0;
    tick(); tick();
    checks++; if (bus.HRQ !== 1'b0) begin failures++; $display("FAIL sw_idle_hrq got=%b exp=0", bus.HRQ); end
    bus.swReqSet = 4'b0001;
    tick();
    bus.swReqSet = '0;
    wait_hrq(ok);
    bus.HLDA = 1'b1;
    tick();
    bus.xferDone = 1'b1;
    bus.swReqSet = 4'b0001;
    tick();
    bus.xferDone = 1'b0;
    bus.swReqSet = '0;
    checks++; if (bus.reqStatus !== 4'b0001) begin failures++; $display("FAIL set_wins got=%b exp=0001", bus.reqStatus); end
    bus.HLDA = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    bit ok;
    set_defaults();
    hard_reset();
    bus.DREQ = 4'b0100;
    wait_hrq(ok);
    bus.HLDA = 1'b1;
    tick();
    checks++; if (bus.DACK !== 4'b0100) begin failures++; $display("FAIL abort_dack_on got=%b exp=0100", bus.DACK); end
    bus.HLDA = 1'b0;
    tick();
    checks++; if (bus.DACK !== 4'b0000) begin failures++; $display("FAIL abort_dack_off got=%b exp=0000", bus.DACK); end
    checks++; if (bus.HRQ !== 1'b0) begin failures++; $display("FAIL abort_hrq got=%b exp=0", bus.HRQ); end
    tick();
    checks++; if (bus.HRQ !== 1'b0) begin failures++; $display("FAIL abort_idle_hrq got=%b exp=0", bus.HRQ); end
    tick();
    checks++; if (bus.HRQ !== 1'b1) begin failures++; $display("FAIL abort_rereq_hrq got=%b exp=1", bus.HRQ); end
    bus.EOP_N = 1'b0;
    bus.xferDone = 1'b1;
    tick();
    bus.EOP_N = 1'b1;
    bus.xferDone = 1'b0;
    checks++; if (bus.HRQ !== 1'b1) begin failures++; $display("FAIL eop_ignored_hrq got=%b exp=1", bus.HRQ); end
    bus.HLDA = 1'b1;
    tick();
    checks++; if (bus.grantChan !== 2'd2) begin failures++; $display("FAIL abort_regrant got=%0d exp=2", bus.grantChan); end
    bus.DREQ = '0;
    bus.HLDA = 1'b0;
    tick(); tick();
  endtask

  task automatic test_polarity();
    bit ok;
    set_defaults();
    bus.dreqSenseLow = 1'b1;
    bus.dackSenseHigh = 1'b0;
    bus.DREQ = 4'b1111;
    hard_reset();
    tick();
    checks++; if (bus.DACK !== 4'b1111) begin failures++; $display("FAIL pol_idle_dack got=%b exp=1111", bus.DACK); end
    bus.DREQ = 4'b1110;
    wait_hrq(ok);
    checks++; if (!ok) begin failures++; $display("FAIL pol_hrq_timeout"); end
    bus.HLDA = 1'b1;
    tick();
    checks++; if (bus.grantChan !== 2'd0) begin failures++; $display("FAIL pol_chan got=%0d exp=0", bus.grantChan); end
    checks++; if (bus.DACK !== 4'b1110) begin failures++; $display("FAIL pol_dack got=%b exp=1110", bus.DACK); end
    bus.EOP_N = 1'b0;
    tick();
    bus.EOP_N = 1'b1;
    bus.DREQ = 4'b1111;
    bus.HLDA = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    bit ok;
    int exp;
    set_defaults();
    hard_reset();
    bus.DREQ = 4'b1000;
    wait_hrq(ok);
    bus.HLDA = 1'b1;
    tick();
    checks++; if (bus.DACK !== 4'b1000) begin failures++; $display("FAIL ar_dack_on got=%b exp=1000", bus.DACK); end
    #2;
    RESET = 1'b0;
    #1;
    checks++; if (bus.HRQ !== 1'b0) begin failures++; $display("FAIL ar_hrq got=%b exp=0", bus.HRQ); end
    checks++; if (bus.DACK !== 4'b0000) begin failures++; $display("FAIL ar_dack got=%b exp=0000", bus.DACK); end
    checks++; if (bus.grantValid !== 1'b0) begin failures++; $display("FAIL ar_gv got=%b exp=0", bus.grantValid); end
    #1;
    RESET = 1'b1;
    sw_model = '0;
    last_model = N - 1;
    bus.HLDA = 1'b0;
    bus.rotPri = 1'b1;
    bus.DREQ = 4'b1111;
    tick();
    wait_hrq(ok);
    bus.HLDA = 1'b1;
    tick();
    exp = exp_winner(model_eff(), 1'b1, last_model);
    checks++; if (bus.grantChan !== 2'(exp)) begin failures++; $display("FAIL ar_rot_chan got=%0d exp=%0d", bus.grantChan, exp); end
    bus.xferDone = 1'b1;
    tick();
    bus.xferDone = 1'b0;
    bus.DREQ = '0;
    bus.HLDA = 1'b0;
    tick();
  endtask

  task automatic test_random();
    bit ok, dis;
    bit [N-1:0] eff, exp_dack, inactive;
    int win, kind;
    set_defaults();
    hard_reset();
    for (int it = 0; it < 60; it++) begin
      bus.maskBits      = N'($urandom);
      bus.rotPri        = 1'($urandom);
      bus.dreqSenseLow  = 1'($urandom);
      bus.dackSenseHigh = 1'($urandom);
      bus.DREQ          = N'($urandom);
      dis               = ($urandom_range(0, 5) == 0);
      bus.ctrlDisable   = dis;
      bus.swReqSet      = N'($urandom & $urandom);
      tick();
      sw_model     = sw_model | bus.swReqSet;
      bus.swReqSet = '0;
      eff          = model_eff();
      inactive     = {N{~bus.dackSenseHigh}};
      if (dis || eff == '0) begin
        tick(); tick();
        checks++; if (bus.HRQ !== 1'b0) begin failures++; $display("FAIL rnd_blocked it=%0d got=%b exp=0", it, bus.HRQ); end
        bus.ctrlDisable = 1'b0;
        if (eff == '0) continue;
      end
      wait_hrq(ok);
      checks++;
      if (!ok) begin
        failures++; $display("FAIL rnd_hrq_timeout it=%0d", it);
        hard_reset();
        continue;
      end
      repeat ($urandom_range(0, 2)) tick();
      bus.HLDA = 1'b1;
      tick();
      win      = exp_winner(eff, bus.rotPri, last_model);
      exp_dack = (N'(1) << win) ^ inactive;
      checks++; if (bus.grantValid !== 1'b1) begin failures++; $display("FAIL rnd_gv it=%0d got=%b exp=1", it, bus.grantValid); end
      checks++; if (bus.grantChan !== 2'(win)) begin failures++; $display("FAIL rnd_chan it=%0d got=%0d exp=%0d", it, bus.grantChan, win); end
      checks++; if (bus.DACK !== exp_dack) begin failures++; $display("FAIL rnd_dack it=%0d got=%b exp=%b", it, bus.DACK, exp_dack); end
      repeat ($urandom_range(0, 2)) begin
        bus.DREQ = N'($urandom);
        tick();
      end
      checks++; if (bus.grantChan !== 2'(win)) begin failures++; $display("FAIL rnd_hold it=%0d got=%0d exp=%0d", it, bus.grantChan, win); end
      kind = $urandom_range(0, 4);
      if (kind == 0) begin
        bus.HLDA = 1'b0;
        tick();
        checks++; if (bus.DACK !== inactive) begin failures++; $display("FAIL rnd_abort_dack it=%0d got=%b exp=%b", it, bus.DACK, inactive); end
        checks++; if (bus.reqStatus !== sw_model) begin failures++; $display("FAIL rnd_abort_status it=%0d got=%b exp=%b", it, bus.reqStatus, sw_model); end
        tick();
      end else begin
        if (kind == 1) bus.EOP_N = 1'b0;
        else bus.xferDone = 1'b1;
        tick();
        bus.EOP_N    = 1'b1;
        bus.xferDone = 1'b0;
        sw_model[win] = 1'b0;
        last_model    = win;
        checks++; if (bus.HRQ !== 1'b0) begin failures++; $display("FAIL rnd_done_hrq it=%0d got=%b exp=0", it, bus.HRQ); end
        checks++; if (bus.DACK !== inactive) begin failures++; $display("FAIL rnd_done_dack it=%0d got=%b exp=%b", it, bus.DACK, inactive); end
        checks++; if (bus.reqStatus !== sw_model) begin failures++; $display("FAIL rnd_done_status it=%0d got=%b exp=%b", it, bus.reqStatus, sw_model); end
        bus.HLDA = 1'b0;
        tick();
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b0;
    sw_model = '0;
    last_model = N - 1;
    test_reset();
    test_fixed_priority();
    test_rotating();
    test_mask_sw();
    test_abort();
    test_polarity();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
